// File: rtl/hamming_pkg.sv
`default_nettype none
// ==========================================================================
// hamming_pkg: shared Hamming/SECDED sizing helpers and reference encoder
// Rev 1.0
// ==========================================================================
package hamming_pkg;

  localparam int LEGACY_DATA_W = 4;
  localparam int MAX_W         = 64;

  function automatic int par_w(input int data_w);
    int r;
    r = 0;
    // Descending scan so the smallest satisfying r is the one kept.
    for (int i = 7; i >= 1; i--) begin
      if ((1 << i) >= data_w + i + 1) r = i;
    end
    return r;
  endfunction

  function automatic bit is_pow2(input int k);
    return (k > 0) && ((k & (k - 1)) == 0);
  endfunction

  // Result is right-aligned: position k lands in bit (code_w - k), overall parity in bit 0.
  function automatic logic [MAX_W-1:0] encode(input logic [MAX_W-1:0] data,
                                               input int data_w, input int ext);
    logic [MAX_W-1:0] pos;
    logic [MAX_W-1:0] rest;
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] code;
    int r;
    int n;
    int cw;
    r    = par_w(data_w);
    n    = data_w + r;
    cw   = n + ((ext != 0) ? 1 : 0);
    pos  = '0;
    rest = data;
    for (int k = 1; k < MAX_W; k++) begin
      if ((k <= n) && !is_pow2(k)) begin
        pos  = pos | ({{(MAX_W-1){1'b0}}, rest[0]} << k);
        rest = rest >> 1;
      end
    end
    // Parity slots are still zero here, so each mask only sees data positions.
    for (int j = 0; j < 7; j++) begin
      if ((1 << j) <= n) begin
        mask = '0;
        for (int k = 1; k < MAX_W; k++) begin
          if ((k & (1 << j)) != 0) mask = mask | (MAX_W'(1) << k);
        end
        pos = pos | (MAX_W'(^(pos & mask)) << (1 << j));
      end
    end
    code = '0;
    for (int k = 1; k < MAX_W; k++) begin
      if ((k <= n) && (((pos >> k) & MAX_W'(1)) != '0)) code = code | (MAX_W'(1) << (cw - k));
    end
    if (ext != 0) code = code | MAX_W'(^pos);
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hamming_skid_fifo.sv
`default_nettype none
// ==========================================================================
// hamming_skid_fifo: 2-entry in-order valid/ready buffer, head held when empty
// Rev 1.0
// ==========================================================================
module hamming_skid_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             push, pop;

  always_comb begin
    push   = in_valid && (cnt_q != 2'd2);
    pop    = (cnt_q != 2'd0) && out_ready;
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = in_data;
        else               tail_d = in_data;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        // Draining the last entry leaves head untouched so code_out holds.
        if (cnt_q == 2'd2) head_d = tail_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          head_d = in_data;
        end else begin
          head_d = tail_q;
          tail_d = in_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assign in_ready  = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = head_q;

endmodule
`default_nettype wire

// File: rtl/hamming_secded_stream_encoder.sv
`default_nettype none
// ==========================================================================
// hamming_secded_stream_encoder: streaming Hamming/SECDED encoder with error injection
// Rev 1.0
// ==========================================================================
module hamming_secded_stream_encoder
  import hamming_pkg::*;
#(
  parameter int  DATA_W  = 4,
  parameter int  EXT_PAR = 1,
  parameter int  CNT_W   = 16,
  localparam int PAR_W   = par_w(DATA_W),
  localparam int N       = DATA_W + PAR_W,
  localparam int CODE_W  = N + EXT_PAR,
  localparam int POS_W   = $clog2(CODE_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic              inj_en,
  input  logic [POS_W-1:0]  inj_pos,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] code_out,
  output logic [CNT_W-1:0]  word_cnt
);

  logic             started_q, started_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [MAX_W-1:0] code_full;
  logic [CODE_W-1:0] code_enc;
  logic             unused_code;
  logic             fifo_ready;
  logic             accept_valid;

  always_comb begin
    code_full = encode(MAX_W'(data_in), DATA_W, EXT_PAR);
    code_enc  = code_full[CODE_W-1:0];
    // Out-of-range positions leave the word clean.
    if (inj_en && (int'(inj_pos) < CODE_W)) code_enc = code_enc ^ (CODE_W'(1) << inj_pos);
  end

  assign unused_code = ^code_full;

  // started_q keeps in_ready low until the first edge after reset release.
  assign accept_valid = in_valid && ena && started_q;
  assign in_ready     = ena && started_q && fifo_ready;

  hamming_skid_fifo #(
    .WIDTH (CODE_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (accept_valid),
    .in_ready  (fifo_ready),
    .in_data   (code_enc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (code_out)
  );

  always_comb begin
    started_d  = 1'b1;
    word_cnt_d = word_cnt_q + CNT_W'(out_valid && out_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      started_q  <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      started_q  <= started_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign word_cnt = word_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hamming_secded_stream_encoder.sv
`default_nettype none
// ==========================================================================
// tb_hamming_secded_stream_encoder: directed checks on three encoder configurations
// Rev 1.0
// ==========================================================================
module tb_hamming_secded_stream_encoder;

  logic        clk = 1'b0;
  logic        rst, ena, in_valid, inj_en, out_ready;
  logic [3:0]  data_in;
  logic [2:0]  inj_pos;
  logic [10:0] c_data;
  logic [3:0]  c_inj_pos;

  logic        a_in_ready, a_out_valid;
  logic [6:0]  a_code;
  logic [15:0] a_cnt;
  logic        b_in_ready, b_out_valid;
  logic [7:0]  b_code;
  logic [2:0]  b_cnt;
  logic        c_in_ready, c_out_valid;
  logic [15:0] c_code;
  logic [15:0] c_cnt;

  int total = 0;
  int bad   = 0;

  logic [3:0] bp [5] = '{4'h3, 4'h5, 4'h6, 4'h9, 4'hC};

  always #5 clk = ~clk;

  hamming_secded_stream_encoder #(.DATA_W(4), .EXT_PAR(0), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .in_ready(a_in_ready),
    .data_in(data_in), .inj_en(inj_en), .inj_pos(inj_pos), .out_valid(a_out_valid),
    .out_ready(out_ready), .code_out(a_code), .word_cnt(a_cnt));

  hamming_secded_stream_encoder #(.DATA_W(4), .EXT_PAR(1), .CNT_W(3)) u_b (
    .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .in_ready(b_in_ready),
    .data_in(data_in), .inj_en(inj_en), .inj_pos(inj_pos), .out_valid(b_out_valid),
    .out_ready(out_ready), .code_out(b_code), .word_cnt(b_cnt));

  hamming_secded_stream_encoder #(.DATA_W(11), .EXT_PAR(1), .CNT_W(16)) u_c (
    .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .in_ready(c_in_ready),
    .data_in(c_data), .inj_en(inj_en), .inj_pos(c_inj_pos), .out_valid(c_out_valid),
    .out_ready(out_ready), .code_out(c_code), .word_cnt(c_cnt));

  // Legacy (7,4) ordering {p1,p2,d0,p3,d1,d2,d3}.
  function automatic logic [6:0] leg(input logic [3:0] v);
    return {v[0]^v[1]^v[3], v[0]^v[2]^v[3], v[0], v[1]^v[2]^v[3], v[1], v[2], v[3]};
  endfunction

  function automatic logic [7:0] ext8(input logic [3:0] v);
    logic [6:0] h;
    h = leg(v);
    return {h, ^h};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; in_valid = 1'b0; inj_en = 1'b0; inj_pos = '0;
    out_ready = 1'b1; data_in = '0; c_data = 11'h7FF; c_inj_pos = '0;
    repeat (2) tick();
    chk("rst_in_ready", a_in_ready, 0);
    chk("rst_out_valid", b_out_valid, 0);
    chk("rst_code", b_code, 0);
    chk("rst_cnt", b_cnt, 0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready_low", b_in_ready, 0);
    tick();
    chk("rel_in_ready_high", b_in_ready, 1);
    chk("rel_c_in_ready", c_in_ready, 1);

    // Full sweep, back-to-back at one word per cycle.
    for (int i = 0; i < 16; i++) begin
      data_in = 4'(i); in_valid = 1'b1;
      tick();
      chk("sweep_valid", a_out_valid, 1);
      chk("sweep_74", a_code, leg(4'(i)));
      chk("sweep_84", b_code, ext8(4'(i)));
    end
    chk("c_7ff", c_code, 16'hFFFF);
    chk("c_valid", c_out_valid, 1);
    data_in = 4'hB; tick();
    chk("a_B", a_code, 7'h55);
    chk("b_B", b_code, 8'hAA);
    data_in = 4'h1; tick();
    chk("a_1", a_code, 7'h70);
    chk("b_1", b_code, 8'hE1);
    data_in = 4'h0; tick();
    chk("b_0", b_code, 8'h00);
    in_valid = 1'b0; tick();
    chk("idle_valid", b_out_valid, 0);
    chk("cnt_a_19", a_cnt, 19);
    chk("cnt_b_wrap3", b_cnt, 3);

    // Error injection.
    in_valid = 1'b1; data_in = 4'hB; inj_en = 1'b1; inj_pos = 3'd3; c_inj_pos = 4'd0;
    tick();
    chk("inj_b3", b_code, 8'hA2);
    chk("inj_a3", a_code, 7'h5D);
    chk("inj_c0", c_code, 16'hFFFE);
    inj_en = 1'b0; tick();
    chk("inj_next_b", b_code, 8'hAA);
    chk("inj_next_a", a_code, 7'h55);
    chk("inj_next_c", c_code, 16'hFFFF);
    inj_en = 1'b1; inj_pos = 3'd7; c_inj_pos = 4'd15; tick();
    chk("inj_a_oob", a_code, 7'h55);
    chk("inj_b7", b_code, 8'h2A);
    chk("inj_c15", c_code, 16'h7FFF);
    in_valid = 1'b0; tick();
    chk("inj_noacc_valid", b_out_valid, 0);
    inj_en = 1'b0; in_valid = 1'b1; c_data = 11'h001; tick();
    chk("inj_not_sticky", b_code, 8'hAA);
    chk("c_001", c_code, 16'hE001);
    in_valid = 1'b0; tick();
    chk("cnt_a_23", a_cnt, 23);
    chk("cnt_b_7", b_cnt, 7);

    // Backpressure.
    out_ready = 1'b0; in_valid = 1'b1; data_in = bp[0]; tick();
    chk("bp_ready1", b_in_ready, 1);
    chk("bp_head0", b_code, ext8(bp[0]));
    data_in = bp[1]; tick();
    chk("bp_full", b_in_ready, 0);
    chk("bp_hold0", b_code, ext8(bp[0]));
    data_in = bp[2]; tick();
    chk("bp_full2", b_in_ready, 0);
    chk("bp_hold0b", b_code, ext8(bp[0]));
    chk("bp_cnt_hold", a_cnt, 23);
    out_ready = 1'b1; tick();
    chk("bp_head1", b_code, ext8(bp[1]));
    chk("bp_ready_again", b_in_ready, 1);
    tick();
    chk("bp_head2", b_code, ext8(bp[2]));
    data_in = bp[3]; tick();
    chk("bp_head3", b_code, ext8(bp[3]));
    data_in = bp[4]; tick();
    chk("bp_head4", b_code, ext8(bp[4]));
    chk("bp_head4_a", a_code, leg(bp[4]));
    in_valid = 1'b0; tick();
    chk("bp_empty", b_out_valid, 0);
    chk("bp_cnt_a", a_cnt, 28);
    chk("bp_cnt_b", b_cnt, 4);

    // Asynchronous reset with two words buffered.
    out_ready = 1'b0; in_valid = 1'b1; data_in = 4'h7; tick();
    data_in = 4'h8; tick();
    in_valid = 1'b0;
    chk("pre_rst_valid", b_out_valid, 1);
    #3 rst = 1'b1;
    #1;
    chk("arst_valid", b_out_valid, 0);
    chk("arst_cnt_a", a_cnt, 0);
    chk("arst_code", b_code, 0);
    chk("arst_in_ready", b_in_ready, 0);
    tick();
    rst = 1'b0;
    chk("arst_rel_low", b_in_ready, 0);
    tick();
    chk("arst_rel_high", b_in_ready, 1);
    chk("arst_no_partial", b_out_valid, 0);

    // ena low mid-stream, then counter wrap at 9 words.
    out_ready = 1'b0; in_valid = 1'b1; data_in = 4'h1; tick();
    data_in = 4'h2; tick();
    ena = 1'b0; out_ready = 1'b1;
    #1;
    chk("ena_in_ready", b_in_ready, 0);
    tick();
    chk("ena_drain_head", b_code, ext8(4'h2));
    chk("ena_drain_valid", b_out_valid, 1);
    chk("ena_in_ready_occ1", b_in_ready, 0);
    tick();
    chk("ena_drained", b_out_valid, 0);
    chk("empty_holds_code", b_code, ext8(4'h2));
    tick();
    chk("ena_no_accept", b_out_valid, 0);
    chk("ena_cnt", a_cnt, 2);
    ena = 1'b1;
    for (int i = 0; i < 7; i++) begin
      data_in = 4'(i + 9);
      tick();
      chk("wrap_stream", b_code, ext8(4'(i + 9)));
    end
    in_valid = 1'b0; tick();
    chk("wrap_cnt_b", b_cnt, 1);
    chk("wrap_cnt_a", a_cnt, 9);
    chk("wrap_cnt_c", c_cnt, 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
